// File: rtl/alu_arbiter.sv
// Purpose: two-requester round-robin front end for one shared combinational ALU.
// Latency: a request that is valid in the cycle after edge N is granted at edge N+1.
//          Its response is valid after edge N+2. Minimum initiation interval is 3 cycles.
// Backpressure: a stalled response freezes the result, owner and operands, and holds both req readys low.
// Ports: clk/rst_n clock and async active-low reset.
//        req{0,1}_{valid,ready,a,b,op} are the request channels.
//        alu_{a,b,op} -> and alu_out <- form the shared ALU port.
//        rsp{0,1}_{valid,ready} are the response channels, with rsp_data shared by both.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } alu_req_t;

  state_t           state_q, state_nxt;
  alu_req_t         lat_q, lat_nxt;
  logic             owner_q, owner_nxt;
  logic             prio_q, prio_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             grant0, grant1;

  // Contention is resolved by prio; a lone requester always wins.
  assign grant0 = req0_valid & (~req1_valid | ~prio_q);
  assign grant1 = req1_valid & (~req0_valid |  prio_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_nxt;
      lat_q    <= lat_nxt;
      owner_q  <= owner_nxt;
      prio_q   <= prio_nxt;
      result_q <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    lat_nxt    = lat_q;
    owner_nxt  = owner_q;
    prio_nxt   = prio_q;
    result_nxt = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // The readys are masked while reset is held, because nothing can be accepted then.
        req0_ready = rst_n & grant0;
        req1_ready = rst_n & grant1;
        if (grant0 | grant1) begin
          lat_nxt   = grant1 ? '{a: req1_a, b: req1_b, op: req1_op}
                             : '{a: req0_a, b: req0_b, op: req0_op};
          owner_nxt = grant1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        result_nxt = alu_out;
        state_nxt  = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid =  owner_q;
        // Only the owner's ready matters. The other requester's ready is ignored.
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          prio_nxt  = ~owner_q;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ALU sees only the latched operands, so its inputs stay quiet while idle.
  assign alu_a    = lat_q.a;
  assign alu_b    = lat_q.b;
  assign alu_op   = lat_q.op;
  assign rsp_data = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]  alu_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data)
  );

  // Shared ALU model. Opcodes 10-15 return 0.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'b0, $signed(a) < $signed(b)};
      4'd9: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // The scoreboard pushes an entry on each request handshake and pops it on each response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req1_valid) chk("one_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
      if (req0_valid && req0_ready) begin
        sb.push_back('{owner: 1'b0, data: alu_model(req0_a, req0_b, req0_op)});
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{owner: 1'b1, data: alu_model(req1_a, req1_b, req1_op)});
        grants.push_back(1);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_owner", {31'b0, rsp1_valid}, {31'b0, e.owner});
          chk("sb_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where the response valid is seen, or when the budget runs out.
  task automatic wait_rsp(input int who);
    int n = 0;
    @(negedge clk);
    while (!(who == 0 ? rsp0_valid : rsp1_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", {31'b0, (who == 0 ? rsp0_valid : rsp1_valid)}, 32'h1);
  endtask

  // This task covers a lone req0 operation. It checks the 2-edge latency and the forwarded operands.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [31:0] exp);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    @(negedge clk);
    chk("single_rdy0", {31'b0, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_exec_rsp0", {31'b0, rsp0_valid}, 32'h0);
    chk("single_alu_a", alu_a, a);
    chk("single_alu_b", alu_b, b);
    chk("single_alu_op", {28'b0, alu_op}, {28'b0, op});
    step();
    @(negedge clk);
    chk("single_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
    chk("single_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    chk("single_data", rsp_data, exp);
    step();
    @(negedge clk);
    chk("single_idle_rsp0", {31'b0, rsp0_valid}, 32'h0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state is checked with the valids high, which shows the readys are held low during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy0", {31'b0, req0_ready}, 32'h0);
    chk("rst_rdy1", {31'b0, req1_ready}, 32'h0);
    chk("rst_rsp0", {31'b0, rsp0_valid}, 32'h0);
    chk("rst_rsp1", {31'b0, rsp1_valid}, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Contention right after reset: req0 wins first, then req1.
    req0_a = 32'd10; req0_b = 32'd4; req0_op = 4'd3;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 4'd8;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("cont_rdy0", {31'b0, req0_ready}, 32'h1);
    chk("cont_rdy1", {31'b0, req1_ready}, 32'h0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("cont_exec_rdy1", {31'b0, req1_ready}, 32'h0);
    wait_rsp(0);
    chk("cont_data0", rsp_data, 32'd6);
    step();
    @(negedge clk);
    chk("cont_rdy1_second", {31'b0, req1_ready}, 32'h1);
    step();
    req1_valid = 1'b0;
    wait_rsp(1);
    chk("cont_data1", rsp_data, 32'd1);
    step();

    run_single(32'd5, 32'd3, 4'd2, 32'd8);
    run_single(32'd7, 32'd7, 4'd12, 32'd0);

    // Backpressure. prio now points at req1. The stall is held 5 cycles, and rsp0_ready is high to show it is ignored.
    req1_a = 32'h8000_0000; req1_b = 32'd31; req1_op = 4'd6;
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd2;
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_rdy1", {31'b0, req1_ready}, 32'h1);
    chk("bp_rdy0", {31'b0, req0_ready}, 32'h0);
    step();
    req1_valid = 1'b0;
    wait_rsp(1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_rsp1_held", {31'b0, rsp1_valid}, 32'h1);
      chk("bp_rsp0_low", {31'b0, rsp0_valid}, 32'h0);
      chk("bp_data", rsp_data, 32'd1);
      chk("bp_rdy0_low", {31'b0, req0_ready}, 32'h0);
      chk("bp_alu_a", alu_a, 32'h8000_0000);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp1_last", {31'b0, rsp1_valid}, 32'h1);
    step();
    @(negedge clk);
    chk("bp_idle_rsp1", {31'b0, rsp1_valid}, 32'h0);
    chk("bp_idle_rdy0", {31'b0, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0;
    wait_rsp(0);
    step();

    // Reset mid-op: the async reset is asserted in EXEC, so the in-flight op must vanish.
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'd2; req0_valid = 1'b1;
    @(negedge clk);
    step();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'h0);
    chk("mid_rst_alu_b", alu_b, 32'h0);
    chk("mid_rst_alu_op", {28'b0, alu_op}, 32'h0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_rsp0", {31'b0, rsp0_valid}, 32'h0);
    chk("mid_rst_rsp1", {31'b0, rsp1_valid}, 32'h0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
      step();
    end

    // Fairness: both requesters stay valid for 6 grants. Each winner gets fresh random operands.
    req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15));
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 80 && grants.size() < 6; n++) begin
      logic g0, g1;
      @(negedge clk);
      g0 = req0_valid & req0_ready;
      g1 = req1_valid & req1_ready;
      step();
      if (g0) begin req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15)); end
      if (g1) begin req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("fair_grants", grants.size(), 32'd6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk("fair_order", grants[i], i % 2);

    repeat (6) step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
